// File: rtl/spi_master.sv
// spi_master: SPI initiator serialising one 16-bit {addr, rw, data} frame per request
module spi_master #(
  parameter int HALF_PERIOD = 8,
  parameter int CS_SETUP    = 8,
  parameter int CS_HOLD     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);
  localparam int M1 = HALF_PERIOD > CS_SETUP ? HALF_PERIOD : CS_SETUP;
  localparam int MX = M1 > CS_HOLD ? M1 : CS_HOLD;
  localparam int CW = $clog2(MX) + 1;
  localparam logic [CW-1:0] HP_T = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] SU_T = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HD_T = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GP_T = CW'(CS_HOLD);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    bit_cnt;
  logic [14:0]   shreg;
  logic [7:0]    rx;
  logic          rw_q;
  // frame sequencer: the MSB lives in mosi_pin, shreg holds the remaining 15 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx       <= '0;
      rw_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
      sclk_pin <= 1'b0;
      cs_pin   <= 1'b1;
      mosi_pin <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start && !busy) begin
            state    <= SETUP;
            busy     <= 1'b1;
            cs_pin   <= 1'b0;
            shreg    <= {addr[5:0], rw, rw ? 8'h00 : wdata};
            mosi_pin <= addr[6];
            rw_q     <= rw;
            bit_cnt  <= '0;
            cnt      <= '0;
            rx       <= '0;
          end
        end
        SETUP: begin
          cnt   <= cnt == SU_T ? '0 : cnt + 1'b1;
          state <= cnt == SU_T ? SHIFT : SETUP;
        end
        SHIFT: begin
          if (cnt != HP_T) cnt <= cnt + 1'b1;
          else begin
            cnt      <= '0;
            sclk_pin <= !sclk_pin;
            if (!sclk_pin) begin
              if (rw_q && bit_cnt >= 5'd8) rx <= {rx[6:0], miso_pin};
            end else begin
              shreg    <= {shreg[13:0], 1'b0};
              mosi_pin <= bit_cnt == 5'd15 ? 1'b0 : shreg[14];
              bit_cnt  <= bit_cnt + 5'd1;
              state    <= bit_cnt == 5'd15 ? HOLD : SHIFT;
            end
          end
        end
        HOLD: begin
          cnt    <= cnt == HD_T ? '0 : cnt + 1'b1;
          cs_pin <= cnt == HD_T;
          state  <= cnt == HD_T ? GAP : HOLD;
        end
        GAP: begin
          if (cnt != GP_T) cnt <= cnt + 1'b1;
          else begin
            cnt   <= '0;
            state <= IDLE;
            done  <= 1'b1;
            if (rw_q) rdata <= rx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized frames checked against a bit-level reference of the SPI frame
module tb_spi_master;
  localparam int HP = 8, SU = 8, HD = 8;
  localparam int LAT = 1 + SU + 32 * HP + 2 * HD;
  logic clk = 0, reset = 1, start = 0, rw = 0, miso = 0;
  logic [6:0] addr = 0;
  logic [7:0] wdata = 0;
  logic busy, done, sclk_pin, cs_pin, mosi_pin;
  logic [7:0] rdata;
  int n_cmp = 0, n_err = 0;
  int rise_cnt = 0, fall_cnt = 0;
  logic [15:0] mosi_cap = 0;
  logic [7:0] slave_byte = 0, exp_rd = 0;

  spi_master #(.HALF_PERIOD(HP), .CS_SETUP(SU), .CS_HOLD(HD)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .sclk_pin(sclk_pin), .cs_pin(cs_pin),
    .mosi_pin(mosi_pin), .miso_pin(miso)
  );

  always #5 clk = ~clk;

  // frame-level bus observer and slave: counts edges, captures MOSI, drives MISO
  always @(negedge cs_pin) begin
    rise_cnt = 0;
    fall_cnt = 0;
    mosi_cap = 0;
  end
  always @(posedge sclk_pin) begin
    rise_cnt++;
    mosi_cap = {mosi_cap[14:0], mosi_pin};
  end
  always @(negedge sclk_pin) begin
    fall_cnt++;
    if (fall_cnt >= 8 && fall_cnt <= 15) miso = slave_byte[15 - fall_cnt];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] frame(input logic r, input logic [6:0] a, input logic [7:0] d);
    return {a, r, r ? 8'h00 : d};
  endfunction

  task automatic run_frame(input logic r, input logic [6:0] a, input logic [7:0] d, input bit poke);
    int cyc = 0;
    slave_byte = 8'($urandom);
    @(negedge clk);
    start = 1; rw = r; addr = a; wdata = d;
    @(posedge clk); #1;
    start = 0; rw = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
    check("busy_after_accept", busy, 1);
    while (!done && cyc < LAT + 50) begin
      @(posedge clk); #1;
      cyc++;
      if (poke && cyc == 100) begin start = 1; addr = ~a; end
      if (poke && cyc == 101) start = 0;
      if (cyc == LAT - 1) check("rdata_before_done", rdata, exp_rd);
    end
    if (r) exp_rd = slave_byte;
    check("latency", cyc, LAT);
    check("mosi_frame", mosi_cap, frame(r, a, d));
    check("rise_edges", rise_cnt, 16);
    check("fall_edges", fall_cnt, 16);
    check("rdata", rdata, exp_rd);
    check("busy_in_done", busy, 1);
    @(posedge clk); #1;
    check("done_pulse_end", done, 0);
    check("busy_cleared", busy, 0);
    if (poke) begin
      repeat (300) begin
        @(posedge clk); #1;
        if (done) check("no_extra_done", done, 0);
      end
      check("idle_after_poke", cs_pin, 1);
    end
  endtask

  initial begin
    int hi, ndone, k;
    logic [6:0] a;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", cs_pin, 1);
    check("rst_sclk", sclk_pin, 0);
    check("rst_mosi", mosi_pin, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    @(negedge clk) reset = 0;

    run_frame(0, 7'h05, 8'hA5, 0);
    run_frame(1, 7'h7F, 8'h00, 0);
    for (int i = 0; i < 8; i++)
      run_frame(1'($urandom), 7'($urandom), 8'($urandom), i == 3);

    a = 7'($urandom);
    slave_byte = 8'($urandom);
    hi = 0; ndone = 0;
    @(negedge clk);
    start = 1; rw = 1; addr = a; wdata = 8'h00;
    for (int c = 0; c < 4 * LAT && ndone < 3; c++) begin
      @(posedge clk); #1;
      if (cs_pin) hi++;
      else begin
        if (hi > 0 && ndone > 0) check("b2b_gap_ok", 32'(hi >= HD + 1), 1);
        hi = 0;
      end
      if (done) begin
        ndone++;
        check("b2b_rises", rise_cnt, 16);
        check("b2b_mosi", mosi_cap, frame(1, a, 8'h00));
        check("b2b_rdata", rdata, slave_byte);
        if (ndone == 3) start = 0;
      end
    end
    exp_rd = slave_byte;
    repeat (LAT + 20) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("b2b_done_count", ndone, 3);

    slave_byte = 8'($urandom);
    @(negedge clk);
    start = 1; rw = 1; addr = 7'h2A;
    @(posedge clk); #1;
    start = 0;
    k = 0;
    while (rise_cnt < 6 && k < LAT) begin
      @(posedge clk); #1;
      k++;
    end
    check("reached_rise6", rise_cnt, 6);
    reset = 1;
    #1;
    check("midrst_cs", cs_pin, 1);
    check("midrst_sclk", sclk_pin, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rdata", rdata, 0);
    exp_rd = 0;
    @(negedge clk) reset = 0;
    ndone = 0;
    repeat (LAT + 20) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_frame(1, 7'h12, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
